// File: rtl/util_lin_int.sv
// util_lin_int: per-channel linear interpolator feeding a DAC that pulls samples via dac_read.
// Ports: aclk/aresetn; s_axis_data_* input stream; m_axis_data_* output strobe+data;
//   interpolate (1=linear by 2^LOG2_RATE, 0=bypass); dac_read pull strobe;
//   underrun sticky flag, underrun_clr, underrun_count (live only with UTIL_LIN_INT_UNDERRUN_CNT_EN).
module util_lin_int #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_RATE  = 3
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         s_axis_data_tvalid,
  output logic                         s_axis_data_tready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_data_tdata,
  output logic                         m_axis_data_tvalid,
  output logic [NUM_CH*DATA_WIDTH-1:0] m_axis_data_tdata,
  input  logic                         interpolate,
  input  logic                         dac_read,
  output logic                         underrun,
  input  logic                         underrun_clr,
  output logic [15:0]                  underrun_count
);

  localparam int W  = NUM_CH * DATA_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int L  = LOG2_RATE;
  localparam int AW = DW + 1 + L;

  typedef logic [L-1:0]         k_t;
  typedef logic signed [AW-1:0] acc_t;

  logic         rdy_q;
  logic         in_full_q, in_full_d;
  logic [W-1:0] in_buf_q, in_buf_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] cur_q, cur_d;
  k_t           k_q, k_d;
  acc_t         acc_q [NUM_CH];
  acc_t         acc_d [NUM_CH];
  logic         vld_q;
  logic [W-1:0] y_q, y_d;
  logic         und_q, und_d;

  logic         k0;
  logic         consume;
  logic         uflow;
  logic         accept;
  acc_t         dnew [NUM_CH];
  acc_t         dcur [NUM_CH];
  acc_t         seed [NUM_CH];
  logic [W-1:0] y_seg;

  // k != 0 only ever occurs inside an interpolating segment,
  // so k itself carries the mode latched at consume time.
  always_comb begin : ctrl
    k0      = (k_q == '0);
    consume = dac_read & k0 & in_full_q;
    uflow   = dac_read & k0 & ~in_full_q;
    s_axis_data_tready = rdy_q & (~in_full_q | consume);
    accept  = s_axis_data_tvalid & s_axis_data_tready;
  end

  // acc holds (prev << L) + k*delta; its upper bits are floor(y_k).
  always_comb begin : chan
    y_seg = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      dnew[c] = acc_t'($signed(in_buf_q[c*DW +: DW]))
              - acc_t'($signed(cur_q[c*DW +: DW]));
      dcur[c] = acc_t'($signed(cur_q[c*DW +: DW]))
              - acc_t'($signed(prev_q[c*DW +: DW]));
      seed[c] = (acc_t'($signed(cur_q[c*DW +: DW])) <<< L)
              + dnew[c];
      y_seg[c*DW +: DW] = acc_q[c][L +: DW];
    end
  end

  always_comb begin : nxt
    in_full_d = in_full_q;
    in_buf_d  = in_buf_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    k_d       = k_q;
    acc_d     = acc_q;
    y_d       = y_q;
    und_d     = und_q;

    if (accept) begin
      in_full_d = 1'b1;
      in_buf_d  = s_axis_data_tdata;
    end else if (consume) begin
      in_full_d = 1'b0;
    end

    if (consume) begin
      prev_d = cur_q;
      cur_d  = in_buf_q;
      acc_d  = seed;
      k_d    = interpolate ? k_t'(1) : '0;
      // y_0 of a new segment is its start point (old cur)
      y_d    = interpolate ? cur_q : in_buf_q;
    end else if (uflow) begin
      y_d = cur_q;
    end else if (dac_read) begin
      y_d = y_seg;
      k_d = k_q + k_t'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        acc_d[c] = acc_q[c] + dcur[c];
      end
    end

    if (underrun_clr) begin
      und_d = 1'b0;
    end else if (uflow) begin
      und_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q     <= 1'b0;
      in_full_q <= 1'b0;
      in_buf_q  <= '0;
      prev_q    <= '0;
      cur_q     <= '0;
      k_q       <= '0;
      vld_q     <= 1'b0;
      y_q       <= '0;
      und_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      rdy_q     <= 1'b1;
      in_full_q <= in_full_d;
      in_buf_q  <= in_buf_d;
      prev_q    <= prev_d;
      cur_q     <= cur_d;
      k_q       <= k_d;
      vld_q     <= dac_read;
      y_q       <= y_d;
      und_q     <= und_d;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign m_axis_data_tvalid = vld_q;
  assign m_axis_data_tdata  = y_q;
  assign underrun           = und_q;

`ifdef UTIL_LIN_INT_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_clr) begin
      ucnt_d = '0;
    end else if (uflow && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_util_lin_int.sv
// tb_util_lin_int: scoreboard bench for util_lin_int.
// Reference model computes y_k = prev + floor((cur-prev)*k/R) directly.
module tb_util_lin_int;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int L   = 3;
  localparam int R   = 1 << L;
  localparam int W   = NCH * DW;
`ifdef UTIL_LIN_INT_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [W-1:0] s_tdata = '0;
  logic         m_tvalid;
  logic [W-1:0] m_tdata;
  logic         interpolate = 1'b1;
  logic         dac_read = 1'b0;
  logic         underrun;
  logic         underrun_clr = 1'b0;
  logic [15:0]  underrun_count;

  always #5 aclk = ~aclk;

  util_lin_int #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .LOG2_RATE(L)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .s_axis_data_tdata  (s_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tdata  (m_tdata),
    .interpolate        (interpolate),
    .dac_read           (dac_read),
    .underrun           (underrun),
    .underrun_clr       (underrun_clr),
    .underrun_count     (underrun_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int           mprev [NCH];
  int           mcur  [NCH];
  logic [W-1:0] mbuf;
  bit           mfull, mrdy, mund;
  int           mk, mcnt;
  bit           exp_vld;
  logic [W-1:0] expq [$];
  logic [W-1:0] olog [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int chv(input logic [W-1:0] w, input int c);
    logic [DW-1:0] s;
    s = w[c*DW +: DW];
    return int'($signed(s));
  endfunction

  function automatic int interp(input int p, input int c, input int k);
    int d, q;
    d = (c - p) * k;
    q = d / R;
    if (d < 0 && (d % R) != 0) q = q - 1;
    return p + q;
  endfunction

  // reference model: evaluates the coming edge from stable inputs
  always @(negedge aclk) begin
    logic [W-1:0] y;
    bit cons, etr;
    if (!aresetn) begin
      for (int c = 0; c < NCH; c++) begin
        mprev[c] = 0;
        mcur[c] = 0;
      end
      mbuf = '0; mfull = 0; mrdy = 0; mund = 0;
      mk = 0; mcnt = 0; exp_vld = 0;
      expq.delete();
      chk("rst_tready", s_tready, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_ucount", underrun_count, 0);
    end else begin
      y = '0;
      cons = dac_read && mk == 0 && mfull;
      etr = mrdy && (!mfull || cons);
      chk("tready", s_tready, etr);
      if (dac_read) begin
        if (mk == 0 && mfull) begin
          for (int c = 0; c < NCH; c++) begin
            mprev[c] = mcur[c];
            mcur[c] = chv(mbuf, c);
          end
          if (interpolate) begin
            for (int c = 0; c < NCH; c++) y[c*DW +: DW] = DW'(mprev[c]);
            mk = 1;
          end else begin
            y = mbuf;
            mk = 0;
          end
        end else if (mk == 0) begin
          for (int c = 0; c < NCH; c++) y[c*DW +: DW] = DW'(mcur[c]);
          mund = 1;
          if (CNT_EN && mcnt < 65535) mcnt++;
        end else begin
          for (int c = 0; c < NCH; c++)
            y[c*DW +: DW] = DW'(interp(mprev[c], mcur[c], mk));
          mk = (mk + 1) % R;
        end
        expq.push_back(y);
        exp_vld = 1;
      end else begin
        exp_vld = 0;
      end
      if (cons) mfull = 0;
      if (s_tvalid && etr) begin
        mfull = 1;
        mbuf = s_tdata;
      end
      if (underrun_clr) begin
        mund = 0;
        mcnt = 0;
      end
      mrdy = 1;
    end
  end

  // monitor
  always @(posedge aclk) begin
    logic [W-1:0] e;
    #2;
    if (aresetn) begin
      chk("tvalid", m_tvalid, exp_vld);
      if (m_tvalid) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: output %0h with nothing expected", m_tdata);
        end else begin
          e = expq.pop_front();
          chk("tdata", m_tdata, e);
        end
        olog.push_back(m_tdata);
      end
      chk("underrun", underrun, mund);
      chk("ucount", underrun_count, mcnt);
    end
  end

  task automatic send(input logic [W-1:0] w);
    bit ok;
    ok = 0;
    s_tvalid = 1;
    s_tdata = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    s_tvalid = 0;
    chk("send_accept", ok, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e16;
    bit stall, found;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1;

    // ramp on ch0, negative floor on ch1, then underrun
    interpolate = 1;
    send({16'h0000, 16'h0080});
    dac_read = 1;
    olog.delete();
    send({16'hFFF9, 16'h0100});
    repeat (20) @(posedge aclk);
    #1 dac_read = 0;
    @(posedge aclk);
    #3;
    chk("ramp_len", olog.size(), 21);
    if (olog.size() == 21) begin
      for (int i = 0; i < 16; i++)
        chk("ramp_ch0", olog[i][15:0], 16 * i);
      for (int i = 0; i < 8; i++) begin
        e16 = 16'(-i);
        chk("neg_ch1", olog[8+i][31:16], e16);
      end
      for (int i = 16; i < 21; i++) begin
        chk("urun_ch0", olog[i][15:0], 16'h0100);
        chk("urun_ch1", olog[i][31:16], 16'hFFF9);
      end
    end
    chk("urun_flag", underrun, 1);
    chk("urun_cnt", underrun_count, CNT_EN ? 5 : 0);

    @(posedge aclk);
    #1 underrun_clr = 1;
    @(posedge aclk);
    #1 underrun_clr = 0;
    #2;
    chk("clr_flag", underrun, 0);
    chk("clr_cnt", underrun_count, 0);

    // bypass back-to-back
    interpolate = 0;
    send({16'h1111, 16'h1111});
    dac_read = 1;
    s_tvalid = 1;
    s_tdata = {16'h2222, 16'h2222};
    olog.delete();
    @(negedge aclk);
    chk("byp_tready0", s_tready, 1);
    @(posedge aclk);
    #1 s_tvalid = 0;
    @(negedge aclk);
    chk("byp_tready1", s_tready, 1);
    @(posedge aclk);
    #1 dac_read = 0;
    #2;
    chk("byp_len", olog.size(), 2);
    if (olog.size() == 2) begin
      chk("byp_0", olog[0], {16'h1111, 16'h1111});
      chk("byp_1", olog[1], {16'h2222, 16'h2222});
    end

    // reset mid-segment at k=4
    interpolate = 1;
    send({16'h4000, 16'hC000});
    dac_read = 1;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge aclk);
      #1;
      if (mk == 4) begin
        found = 1;
        break;
      end
    end
    chk("reach_k4", found, 1);
    aresetn = 0;
    #1;
    chk("arst_tvalid", m_tvalid, 0);
    chk("arst_tdata", m_tdata, 0);
    chk("arst_tready", s_tready, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    olog.delete();
    send({16'h0100, 16'h0040});
    repeat (12) @(posedge aclk);
    #3;
    if (olog.size() > 0) chk("post_rst_first", olog[0], 0);
    else chk("post_rst_len", olog.size(), 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge aclk);
      stall = s_tvalid && !s_tready;
      @(posedge aclk);
      #1;
      if (!stall) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata = $urandom;
      end
      dac_read = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) interpolate = ~interpolate;
      underrun_clr = ($urandom_range(0, 63) == 0);
    end
    @(posedge aclk);
    #1;
    dac_read = 0;
    s_tvalid = 0;
    underrun_clr = 0;
    repeat (3) @(posedge aclk);
    #3;
    chk("drain", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/util_lin_int.md
UTIL_LIN_INT -- requirements
Module: util_lin_int

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of channels packed in each data word (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, signed two's-complement sample width per channel (8..24).
REQ-003 SHALL have parameter LOG2_RATE, default 3, interpolation rate R = 2^LOG2_RATE (1..5).
REQ-004 SHALL have a single clock and an asynchronous active-low reset: aclk (in, 1) is the clock; aresetn (in, 1) is the reset.
REQ-005 SHALL have port s_axis_data_tvalid  in  1  input sample valid.
REQ-006 SHALL have port s_axis_data_tready  out  1  input accept.
REQ-007 SHALL have port s_axis_data_tdata  in  NUM_CH*DATA_WIDTH  packed samples, channel 0 in the LSBs.
REQ-008 SHALL have port m_axis_data_tvalid  out  1  output sample strobe.
REQ-009 SHALL have port m_axis_data_tdata  out  NUM_CH*DATA_WIDTH  interpolated samples, same packing.
REQ-010 SHALL have port interpolate  in  1  1 = linear interpolate by R, 0 = bypass.
REQ-011 SHALL have port dac_read  in  1  DAC pull strobe requesting one output sample.
REQ-012 SHALL have port underrun  out  1  sticky underrun flag.
REQ-013 SHALL have port underrun_clr  in  1  synchronous clear of underrun and underrun_count.
REQ-014 SHALL have port underrun_count  out  16  saturating underrun counter (see Configuration).

Function
REQ-015 SHALL hold one input buffer (in_buf, in_full), per-channel segment registers prev/cur, and a phase counter k in 0..R-1.
REQ-016 SHALL drive s_axis_data_tready = !in_full OR consume; consume is the cycle the engine takes in_buf, giving one-word-per-cycle throughput.
REQ-017 SHALL capture s_axis_data_tdata into in_buf on tvalid&&tready; no data may be lost or duplicated.
REQ-018 SHALL, on a dac_read cycle with k==0 and in_full, consume: prev<=cur, cur<=in_buf, and latch the interpolate mode for the new segment.
REQ-019 SHALL, in interpolate mode, output y_k = prev + floor(((cur-prev)*k)/2^LOG2_RATE) per channel, with k advancing by 1 (wrap R-1->0) on each dac_read.
REQ-020 SHALL compute y_k with a DATA_WIDTH+1+LOG2_RATE signed accumulator (prev<<L plus delta per step), arithmetic right shift, floor rounding, no saturation (result is always in range).
REQ-021 SHALL, in bypass mode, output the consumed sample directly, keep k at 0, and consume on every dac_read.
REQ-022 SHALL register outputs: m_axis_data_tvalid is asserted exactly one cycle after each dac_read cycle, never otherwise.
REQ-023 SHALL, on underrun (dac_read, k==0, !in_full), re-output cur on all channels, keep k at 0, set underrun, and still assert m_axis_data_tvalid.
REQ-024 SHALL have underrun_clr take priority over a simultaneous set.
REQ-025 SHALL ignore interpolate changes mid-segment; a new mode takes effect at the next consume.
REQ-026 SHALL have no effect on state from dac_read while in_full=0 and k!=0 other than advancing k (segment completes from registers).

Reset
REQ-027 SHALL, while aresetn=0 (asynchronous), hold: in_full=0, prev=cur=0, k=0, m_axis_data_tvalid=0, m_axis_data_tdata=0, s_axis_data_tready=0, underrun=0, underrun_count=0.
REQ-028 SHALL assert s_axis_data_tready on the first clock after reset release; a reset mid-segment discards the buffered sample and the segment.

Configuration
REQ-029 SHALL implement macro UTIL_LIN_INT_UNDERRUN_CNT_EN: defined, underrun_count increments once per underrun event, saturating at 0xFFFF; undefined, underrun_count is tied to 0 and the counter logic is absent.

Verification (NUM_CH=2, DATA_WIDTH=16, LOG2_RATE=3, dac_read continuous)
REQ-030 SHALL verify ramp: ch0 inputs 0x0080, 0x0100 -> outputs 0x0000, 0x0010 ... 0x0070, 0x0080, 0x0090 ... 0x00F0.
REQ-031 SHALL verify negative: ch1 inputs 0x0000, 0xFFF9 -> segment outputs 0x0000, 0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC, 0xFFFB, 0xFFFA, 0xFFF9 (floor).
REQ-032 SHALL verify underrun: input stops after 0x0100 -> at the next k==0, 0x0100 repeats every cycle, underrun=1, underrun_count counts to 5 over 5 cycles (macro on) or stays 0 (macro off); underrun_clr returns both to 0.
REQ-033 SHALL verify bypass: interpolate=0, inputs 0x1111, 0x2222 back-to-back with tvalid held -> outputs 0x1111, 0x2222 on consecutive cycles, tready never drops.
REQ-034 SHALL verify reset: aresetn low at k=4 -> outputs and tready go 0 immediately; after release the first output is 0x0000 followed by the next fresh segment.
